// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared shape codes, FSM state codes and span widths for shape_rasterizer.
// Clipping is selected by RENDER_CLIP_EN in the files that import this package.
package render_pkg;

  localparam int COORD_W = 10;
  localparam int SHAPE_W = 12;
  localparam int SPAN_W  = COORD_W + 1;

  typedef enum logic [SHAPE_W-1:0] {
    SQUARE = 12'd0,
    TRI_TL = 12'd1,
    TRI_TR = 12'd2,
    TRI_BL = 12'd3,
    TRI_BR = 12'd4,
    PARA   = 12'd5
  } shape_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROW  = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic shape_known(input logic [SHAPE_W-1:0] ty);
    return ty <= SHAPE_W'(PARA);
  endfunction

endpackage

// File: rtl/shape_interval.sv
// rtl/shape_interval.sv - combinational row span (s, t) for one shape row.
// With RENDER_CLIP_EN the span saturates instead of wrapping and is clamped to the screen.
module shape_interval
  import render_pkg::*;
#(
  parameter int CORDW = 10,
  parameter int DATAW = 12
`ifdef RENDER_CLIP_EN
  ,
  parameter int SCREEN_W = 640
`endif
) (
  input  logic [DATAW-1:0] ty,
  input  logic [CORDW-1:0] x0,
  input  logic [CORDW-1:0] n,
  input  logic [CORDW-1:0] r,
  output logic [CORDW:0]   s,
  output logic [CORDW:0]   t,
  output logic             empty
);

`ifdef RENDER_CLIP_EN
  // One spare bit so span overflow can be detected and saturated.
  localparam int WW = CORDW + 2;
`else
  localparam int WW = CORDW + 1;
`endif

  logic [WW-1:0] xw, rw, nm1;
  logic [WW-1:0] s_w, t_w;
  logic          known;

  always_comb begin
    xw    = WW'(x0);
    rw    = WW'(r);
    nm1   = WW'(n) - WW'(1);
    s_w   = xw;
    t_w   = xw + nm1;
    known = 1'b1;
    case (ty)
      DATAW'(SQUARE): ;
      DATAW'(TRI_TL): t_w = xw + nm1 - rw;
      DATAW'(TRI_TR): s_w = xw + rw;
      DATAW'(TRI_BL): t_w = xw + rw;
      DATAW'(TRI_BR): s_w = xw + nm1 - rw;
      DATAW'(PARA): begin
        s_w = xw + nm1 - rw;
        t_w = xw + nm1 - rw + nm1;
      end
      default: known = 1'b0;
    endcase
  end

`ifdef RENDER_CLIP_EN
  localparam logic [WW-1:0] SPAN_MAX = WW'((1 << (CORDW + 1)) - 1);
  localparam logic [WW-1:0] X_MAX    = WW'(SCREEN_W - 1);
  localparam logic [WW-1:0] X_LIMIT  = WW'(SCREEN_W);

  logic [WW-1:0] s_sat, t_sat, t_clip;

  always_comb begin
    s_sat  = (s_w > SPAN_MAX) ? SPAN_MAX : s_w;
    t_sat  = (t_w > SPAN_MAX) ? SPAN_MAX : t_w;
    t_clip = (t_sat > X_MAX) ? X_MAX : t_sat;
    s      = s_sat[CORDW:0];
    t      = t_clip[CORDW:0];
    empty  = !known || (s_sat >= X_LIMIT) || (s_sat > t_clip);
  end
`else
  assign s     = s_w;
  assign t     = t_w;
  assign empty = !known;
`endif

endmodule

// File: rtl/shape_rasterizer.sv
// rtl/shape_rasterizer.sv - walks a latched shape row by row, one pixel per enabled cycle.
// Optional screen clipping is compiled in with RENDER_CLIP_EN.
module shape_rasterizer
  import render_pkg::*;
#(
  parameter int CORDW    = 10,
  parameter int DATAW    = 12,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             oe,
  input  logic [DATAW-1:0] ty,
  input  logic [CORDW-1:0] x0,
  input  logic [CORDW-1:0] y0,
  input  logic [DATAW-1:0] size,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic             drawing,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [DATAW-1:0] ty_q, ty_d;
  logic [CORDW-1:0] x0_q, x0_d;
  logic [CORDW-1:0] n_q, n_d;
  logic [CORDW-1:0] r_q, r_d;
  logic [CORDW-1:0] x_q, x_d;
  logic [CORDW-1:0] y_q, y_d;
  logic [CORDW-1:0] t_q, t_d;

  logic [CORDW:0]   span_s, span_t;
  logic             span_empty;
  logic             last_row;
  logic             off_screen;
  logic             unused_bits;

  shape_interval #(
    .CORDW(CORDW),
    .DATAW(DATAW)
`ifdef RENDER_CLIP_EN
    ,
    .SCREEN_W(SCREEN_W)
`endif
  ) u_interval (
    .ty   (ty_q),
    .x0   (x0_q),
    .n    (n_q),
    .r    (r_q),
    .s    (span_s),
    .t    (span_t),
    .empty(span_empty)
  );

  assign last_row    = (r_q == n_q - CORDW'(1));
  assign unused_bits = ^{size[DATAW-1:CORDW], span_s[CORDW], span_t[CORDW]};

`ifdef RENDER_CLIP_EN
  // y cannot wrap before reaching SCREEN_H, so the low bits are enough here.
  assign off_screen = ({1'b0, y_q} >= (CORDW + 1)'(SCREEN_H));
`else
  assign off_screen = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ty_d    = ty_q;
    x0_d    = x0_q;
    n_d     = n_q;
    r_d     = r_q;
    x_d     = x_q;
    y_d     = y_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ty_d = ty;
          x0_d = x0;
          n_d  = size[CORDW-1:0];
          r_d  = '0;
          y_d  = y0;
          if (size[CORDW-1:0] == '0 || !shape_known(SHAPE_W'(ty)))
            state_d = ST_DONE;
          else
            state_d = ST_ROW;
        end
      end
      ST_ROW: begin
        if (off_screen) begin
          state_d = ST_DONE;
        end else if (span_empty) begin
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            r_d = r_q + CORDW'(1);
            y_d = y_q + CORDW'(1);
          end
        end else begin
          x_d     = span_s[CORDW-1:0];
          t_d     = span_t[CORDW-1:0];
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (oe) begin
          if (x_q == t_q) begin
            if (last_row) begin
              state_d = ST_DONE;
            end else begin
              r_d     = r_q + CORDW'(1);
              y_d     = y_q + CORDW'(1);
              state_d = ST_ROW;
            end
          end else begin
            x_d = x_q + CORDW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ty_q    <= '0;
      x0_q    <= '0;
      n_q     <= '0;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      ty_q    <= ty_d;
      x0_q    <= x0_d;
      n_q     <= n_d;
      r_q     <= r_d;
      x_q     <= x_d;
      y_q     <= y_d;
      t_q     <= t_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign drawing = (state_q == ST_SCAN) && oe;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_shape_rasterizer.sv
// tb/tb_shape_rasterizer.sv - randomized bench for shape_rasterizer against a row/span reference model.
// Covers RENDER_CLIP_EN behaviour when the bench is built with that macro.
module tb_shape_rasterizer;

  localparam int MAXC = 4096;
  localparam int SW   = 640;
  localparam int SH   = 480;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        oe;
  logic [11:0] ty;
  logic [9:0]  x0;
  logic [9:0]  y0;
  logic [11:0] size;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        drawing;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectation: 0 = no pixel info, 1 = pixel drawn, 2 = stalled holding the pixel.
  int oe_arr[MAXC];
  int exp_kind[MAXC];
  int exp_x[MAXC];
  int exp_y[MAXC];

  shape_rasterizer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .oe     (oe),
    .ty     (ty),
    .x0     (x0),
    .y0     (y0),
    .size   (size),
    .x      (x),
    .y      (y),
    .drawing(drawing),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: each row is one setup cycle then its pixels, each waiting for oe.
  function automatic int build_model(input int tyv, input int x0v, input int y0v, input int n);
    int cyc;
    int s;
    int t;
    int yy;
    cyc = 1;
    for (int i = 0; i < MAXC; i++) exp_kind[i] = 0;
    if (n == 0 || tyv > 5) return 1;
    for (int r = 0; r < n; r++) begin
      yy = y0v + r;
`ifdef RENDER_CLIP_EN
      if (yy >= SH) return cyc + 1;
`endif
      case (tyv)
        0: begin s = x0v;         t = x0v + n - 1;     end
        1: begin s = x0v;         t = x0v + n - 1 - r; end
        2: begin s = x0v + r;     t = x0v + n - 1;     end
        3: begin s = x0v;         t = x0v + r;         end
        4: begin s = x0v + n-1-r; t = x0v + n - 1;     end
        default: begin s = x0v + n - 1 - r; t = s + n - 1; end
      endcase
`ifdef RENDER_CLIP_EN
      if (s > 2047) s = 2047;
      if (t > 2047) t = 2047;
      if (t > SW - 1) t = SW - 1;
      if (s >= SW || s > t) begin
        cyc++;
        continue;
      end
`endif
      cyc++;
      for (int xx = s; xx <= t; xx++) begin
        while (cyc < MAXC - 2 && oe_arr[cyc] == 0) begin
          exp_kind[cyc] = 2;
          exp_x[cyc] = xx & 1023;
          exp_y[cyc] = yy & 1023;
          cyc++;
        end
        exp_kind[cyc] = 1;
        exp_x[cyc] = xx & 1023;
        exp_y[cyc] = yy & 1023;
        cyc++;
      end
    end
    return cyc;
  endfunction

  // oe_mode: 0 always high, 1 random, 2 high on odd cycles only.
  task automatic run_shape(input string name, input int tyv, input int x0v, input int y0v,
                           input int sizev, input int oe_mode, input int again_cyc,
                           output int obs_done);
    int exp_done;
    for (int i = 0; i < MAXC; i++) begin
      if (oe_mode == 0) oe_arr[i] = 1;
      else if (oe_mode == 1) oe_arr[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      else oe_arr[i] = i % 2;
    end
    exp_done = build_model(tyv, x0v, y0v, sizev & 1023);
    obs_done = -1;
    ty    = 12'(tyv);
    x0    = 10'(x0v);
    y0    = 10'(y0v);
    size  = 12'(sizev);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= exp_done; c++) begin
      oe    = oe_arr[c][0];
      start = (c == again_cyc);
      ty    = 12'($urandom);
      x0    = 10'($urandom);
      y0    = 10'($urandom);
      size  = 12'($urandom);
      @(negedge clk);
      if (done === 1'b1 && obs_done < 0) obs_done = c;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, c, busy);
      end
      checks++;
      if (done !== (c == exp_done)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b want %b", name, c, done, (c == exp_done));
      end
      checks++;
      if (drawing !== (exp_kind[c] == 1)) begin
        errors++;
        $display("FAIL %s drawing cycle %0d: got %b want %b", name, c, drawing, (exp_kind[c] == 1));
      end
      if (exp_kind[c] != 0) begin
        checks++;
        if (x !== 10'(exp_x[c]) || y !== 10'(exp_y[c])) begin
          errors++;
          $display("FAIL %s pixel cycle %0d: got (%0d,%0d) want (%0d,%0d)",
                   name, c, x, y, exp_x[c], exp_y[c]);
        end
      end
      if (c < exp_done) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    oe = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle after done: got busy=%b done=%b want 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; oe = 1'b1;
    ty = '0; x0 = '0; y0 = '0; size = '0;
    #12;
    checks++;
    if ({x, y, drawing, busy, done} !== 23'd0) begin
      errors++;
      $display("FAIL reset_values: got x=%0d y=%0d drawing=%b busy=%b done=%b want all 0",
               x, y, drawing, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_square();
    int od;
    run_shape("square", 0, 10, 20, 3, 0, 4, od);
    checks++;
    if (od != 13) begin
      errors++;
      $display("FAIL square_done_cycle: got %0d want 13", od);
    end
  endtask

  task automatic test_tri_br();
    int od;
    run_shape("tri_br", 4, 0, 0, 4, 0, 0, od);
    checks++;
    if (od != 15) begin
      errors++;
      $display("FAIL tri_br_done_cycle: got %0d want 15", od);
    end
  endtask

  task automatic test_para_stall();
    int od;
    run_shape("para_stall", 5, 0, 0, 2, 2, 0, od);
    checks++;
    if (od != 10) begin
      errors++;
      $display("FAIL para_done_cycle: got %0d want 10", od);
    end
  endtask

  task automatic test_empty();
    int od;
    run_shape("empty_size0", 0, 5, 5, 0, 0, 0, od);
    checks++;
    if (od != 1) begin
      errors++;
      $display("FAIL empty_size0_done: got %0d want 1", od);
    end
    run_shape("empty_ty7", 7, 5, 5, 3, 0, 0, od);
    checks++;
    if (od != 1) begin
      errors++;
      $display("FAIL empty_ty7_done: got %0d want 1", od);
    end
    run_shape("empty_highbits", 0, 5, 5, 12'h400, 0, 0, od);
    checks++;
    if (od != 1) begin
      errors++;
      $display("FAIL empty_highbits_done: got %0d want 1", od);
    end
  endtask

  task automatic test_all_types();
    int od;
    for (int k = 0; k < 6; k++)
      run_shape("all_types", k, $urandom_range(0, 1023), $urandom_range(0, 1023), 4, 0, 2, od);
  endtask

  task automatic test_random();
    int od;
    for (int k = 0; k < 25; k++)
      run_shape("random", $urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 8) | ($urandom_range(0, 3) << 10), 1,
                $urandom_range(0, 3), od);
  endtask

  task automatic test_back_to_back();
    int od;
    run_shape("b2b_first", 1, 1020, 1021, 5, 0, 0, od);
    run_shape("b2b_second", 3, 3, 7, 5, 1, 0, od);
  endtask

  task automatic test_reset_mid();
    int od;
    bit seen;
    seen = 1'b0;
    ty = 12'd0; x0 = 10'd100; y0 = 10'd50; size = 12'd6; oe = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (drawing === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_reach_scan: got no drawing within 20 cycles want drawing");
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({x, y, drawing, busy, done} !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got x=%0d y=%0d drawing=%b busy=%b done=%b want all 0",
               x, y, drawing, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold: got done=%b busy=%b want 0 0", done, busy);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    run_shape("after_reset", 2, 30, 40, 3, 0, 0, od);
  endtask

`ifdef RENDER_CLIP_EN
  task automatic test_clip();
    int od;
    run_shape("clip_corner", 0, 638, 478, 4, 0, 0, od);
    checks++;
    if (od != 8) begin
      errors++;
      $display("FAIL clip_done_cycle: got %0d want 8", od);
    end
    run_shape("clip_para", 5, 630, 470, 8, 1, 0, od);
  endtask
`endif

  initial begin
    test_reset();
    test_square();
    test_tri_br();
    test_para_stall();
    test_empty();
    test_all_types();
    test_back_to_back();
    test_random();
`ifdef RENDER_CLIP_EN
    test_clip();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
